apb_cmd_master: RTL and testbench

- Upstream command front-end for the APB slave register block. Buffers write/read commands from a simple valid/ready source in a small FIFO.
- Converts each command into a compliant APB transfer: IDLE -> SETUP -> ACCESS, with Pready wait states and a timeout.
- Returns read data and completion status on a one-cycle response strobe.

---
 rtl/apb_cmd_master.sv | 143 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Buffers valid/ready commands in a FIFO and runs each as an APB IDLE->SETUP->ACCESS transfer with a wait-state timeout.
// Accept-to-Psel 1 cycle, to rsp_valid 3 cycles with no waits; cmd_ready drops when the FIFO is full, and rsp_valid has no backpressure.
module apb_cmd_master #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              Psel,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state;
  logic [WW-1:0]     r_wait;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_busy;

  logic              w_push;
  logic              w_pop;
  logic              w_ok;
  logic              w_abort;
  logic              w_fin;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic [EW-1:0]     w_head;

  // Gated by reset so every output reads 0 while Prst is held.
  assign cmd_ready = !Prst && (r_count != FULL);

  assign w_push      = cmd_valid && cmd_ready;
  assign w_ok        = (r_state == S_ACCESS) && Pready;
  assign w_abort     = (r_state == S_ACCESS) && !Pready && (r_wait == WAIT_LAST);
  assign w_fin       = w_ok || w_abort;
  assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_fin);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_fin) w_state_nxt = w_pop ? S_SETUP : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_state   <= w_state_nxt;
      r_psel    <= (w_state_nxt != S_IDLE);
      r_penable <= (w_state_nxt == S_ACCESS);
      r_busy    <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr                      <= r_rd_ptr + PW'(1);
        {r_pwrite, r_paddr, r_pwdata} <= w_head;
        r_wait                        <= '0;
      end else if ((r_state == S_ACCESS) && !Pready && !w_abort) begin
        r_wait <= r_wait + WW'(1);
      end
      r_rsp_valid <= w_fin;
      if (w_fin) begin
        r_rsp_write <= r_pwrite;
        r_rsp_err   <= w_abort;
        r_rsp_rdata <= (w_ok && !r_pwrite) ? Prdata : '0;
      end
    end
  end

  assign Psel      = r_psel;
  assign Penable   = r_penable;
  assign Pwrite    = r_pwrite;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a scripted APB slave logs every transfer and response, and tasks compare the logs to expectations.
module tb_apb_cmd_master;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic              Pclk = 1'b0;
  logic              Prst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              Psel, Penable, Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata, Prdata;
  logic              Pready;
  logic              rsp_valid, rsp_write, rsp_err, busy;
  logic [DATA_W-1:0] rsp_rdata;

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Pclk(Pclk), .Prst(Prst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    logic        write;
    logic [2:0]  addr;
    logic [15:0] wdata;
    int          wait_n;
    logic [15:0] rdata;
    int          en_cycles;
    bit          stable;
    int          start_cyc;
    int          end_cyc;
  } xfer_t;

  typedef struct {
    logic        write;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  xfer_t       xlog[$];
  rsp_t        rlog[$];
  int          wait_q[$];
  logic [15:0] rdata_q[$];
  xfer_t       cur;
  bit          in_xfer;
  bit          prev_rv;
  int          acc_idx;
  int          cyc;
  int          pulse_err;
  int          checks;
  int          failures;

  // Slave: each transfer inserts wait_n low-Pready ACCESS cycles, then raises Pready.
  initial begin
    rsp_t r;
    Pready = 1'b0; Prdata = '0; in_xfer = 0; prev_rv = 0; acc_idx = 0; cyc = 0; pulse_err = 0;
    forever begin
      @(negedge Pclk);
      cyc++;
      if (Prst === 1'b1) begin
        in_xfer = 0;
        Pready  = 1'b0;
      end else begin
        if (in_xfer && !(Psel && Penable)) begin
          xlog.push_back(cur);
          in_xfer = 0;
        end
        if (Psel && !Penable) begin
          cur.write     = Pwrite;
          cur.addr      = Paddr;
          cur.wdata     = Pwdata;
          cur.wait_n    = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          cur.rdata     = (rdata_q.size() > 0) ? rdata_q.pop_front() : 16'($urandom);
          cur.en_cycles = 0;
          cur.stable    = 1;
          cur.start_cyc = cyc;
          cur.end_cyc   = cyc;
          in_xfer = 1;
          acc_idx = 0;
          Prdata  = cur.rdata;
          Pready  = 1'b0;
        end else if (Psel && Penable && in_xfer) begin
          cur.en_cycles++;
          cur.end_cyc = cyc;
          if (Pwrite !== cur.write || Paddr !== cur.addr || Pwdata !== cur.wdata) cur.stable = 0;
          Pready = (acc_idx == cur.wait_n);
          acc_idx++;
        end else begin
          Pready = 1'b0;
        end
      end
      if (rsp_valid === 1'b1) begin
        if (prev_rv) pulse_err++;
        r.write = rsp_write; r.rdata = rsp_rdata; r.err = rsp_err; r.cyc = cyc;
        rlog.push_back(r);
      end
      prev_rv = (rsp_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push(input logic w, input logic [2:0] a, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge Pclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge Pclk);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready);
    end else begin
      @(posedge Pclk);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int t;
    t = 0;
    while (rlog.size() < n && t < budget) begin
      @(negedge Pclk);
      t++;
    end
    checks++;
    if (rlog.size() < n) begin
      failures++;
      $display("FAIL rsp_count: got %0d required %0d", rlog.size(), n);
    end
    repeat (2) @(negedge Pclk);
  endtask

  task automatic clear_logs();
    xlog.delete(); rlog.delete(); wait_q.delete(); rdata_q.delete(); pulse_err = 0;
  endtask

  task automatic test_reset();
    Prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge Pclk);
    checks++;
    if ({Psel, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: psel=%b pen=%b paddr=%h pwdata=%h rv=%b busy=%b rdy=%b required all 0",
               Psel, Penable, Paddr, Pwdata, rsp_valid, busy, cmd_ready);
    end
    Prst = 1'b0;
    @(negedge Pclk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_write();
    clear_logs();
    push(1'b1, 3'b010, 16'h0009);
    @(negedge Pclk);
    checks++;
    if (Psel !== 1'b0) begin failures++; $display("FAIL sw_idle: psel=%b required 0", Psel); end
    @(negedge Pclk);
    checks++;
    if ({Psel, Penable, Pwrite, Paddr, Pwdata} !== {1'b1, 1'b0, 1'b1, 3'd2, 16'h0009}) begin
      failures++;
      $display("FAIL sw_setup: psel=%b pen=%b pw=%b paddr=%h pwdata=%h required 1 0 1 2 0009", Psel, Penable, Pwrite, Paddr, Pwdata);
    end
    @(negedge Pclk);
    checks++;
    if ({Psel, Penable, Pwrite, Paddr, Pwdata} !== {1'b1, 1'b1, 1'b1, 3'd2, 16'h0009}) begin
      failures++;
      $display("FAIL sw_access: psel=%b pen=%b pw=%b paddr=%h pwdata=%h required 1 1 1 2 0009", Psel, Penable, Pwrite, Paddr, Pwdata);
    end
    @(negedge Pclk);
    checks++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, Psel} !== {1'b1, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL sw_rsp: rv=%b rw=%b err=%b rdata=%h psel=%b required 1 1 0 0000 0", rsp_valid, rsp_write, rsp_err, rsp_rdata, Psel);
    end
    @(negedge Pclk);
    checks++;
    if ({rsp_valid, rsp_write, busy} !== {1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sw_after: rv=%b rw=%b busy=%b required 0 1 0", rsp_valid, rsp_write, busy);
    end
  endtask

  task automatic test_read_wait();
    clear_logs();
    wait_q.push_back(3);
    rdata_q.push_back(16'h0001);
    push(1'b0, 3'b101, 16'($urandom));
    wait_rsp(1, 60);
    checks++;
    if (xlog.size() != 1 || xlog[0].en_cycles != 4 || xlog[0].addr !== 3'd5 || !xlog[0].stable) begin
      failures++;
      $display("FAIL rw_xfer: n=%0d en_cycles=%0d addr=%h stable=%0d required 1 4 5 1", xlog.size(),
               (xlog.size() > 0) ? xlog[0].en_cycles : -1, (xlog.size() > 0) ? xlog[0].addr : 3'd0,
               (xlog.size() > 0) ? xlog[0].stable : 1'b0);
    end
    checks++;
    if (rlog.size() != 1 || rlog[0].rdata !== 16'h0001 || rlog[0].err !== 1'b0 || rlog[0].write !== 1'b0) begin
      failures++;
      $display("FAIL rw_rsp: n=%0d rdata=%h err=%b write=%b required 1 0001 0 0", rlog.size(),
               (rlog.size() > 0) ? rlog[0].rdata : 16'hxxxx, (rlog.size() > 0) ? rlog[0].err : 1'bx,
               (rlog.size() > 0) ? rlog[0].write : 1'bx);
    end
  endtask

  task automatic test_fifo_full();
    logic [15:0] d[5];
    clear_logs();
    wait_q.push_back(8);
    for (int i = 1; i < 5; i++) wait_q.push_back(0);
    for (int i = 0; i < 5; i++) begin
      d[i] = 16'($urandom);
      push(1'(i % 2), 3'(i + 1), d[i]);
    end
    @(negedge Pclk);
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ff_full: cmd_ready=%b required 0", cmd_ready); end
    repeat (3) @(negedge Pclk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ff_stall: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
    end
    wait_rsp(5, 200);
    checks++;
    if (xlog.size() != 5 || rlog.size() != 5 || pulse_err != 0) begin
      failures++;
      $display("FAIL ff_counts: xfers=%0d rsps=%0d pulse_err=%0d required 5 5 0", xlog.size(), rlog.size(), pulse_err);
    end
    for (int i = 0; i < 5 && i < xlog.size() && i < rlog.size(); i++) begin
      checks++;
      if (xlog[i].addr !== 3'(i + 1) || xlog[i].write !== 1'(i % 2) || xlog[i].wdata !== d[i] ||
          rlog[i].cyc != xlog[i].end_cyc + 1 || rlog[i].err !== 1'b0 ||
          (i > 0 && xlog[i].start_cyc != xlog[i-1].end_cyc + 1)) begin
        failures++;
        $display("FAIL ff_order[%0d]: addr=%h write=%b wdata=%h start=%0d rsp_cyc=%0d required addr=%h write=%b wdata=%h back-to-back",
                 i, xlog[i].addr, xlog[i].write, xlog[i].wdata, xlog[i].start_cyc, rlog[i].cyc, 3'(i + 1), 1'(i % 2), d[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    wait_q.push_back(TIMEOUT - 1);
    wait_q.push_back(TIMEOUT + 3);
    rdata_q.push_back(16'h1234);
    rdata_q.push_back(16'hBEEF);
    push(1'b0, 3'b111, 16'h0);
    push(1'b0, 3'b111, 16'h0);
    wait_rsp(2, 200);
    checks++;
    if (xlog.size() != 2 || rlog.size() != 2) begin
      failures++;
      $display("FAIL to_counts: xfers=%0d rsps=%0d required 2 2", xlog.size(), rlog.size());
    end else begin
      checks++;
      if (xlog[0].en_cycles != TIMEOUT || rlog[0].err !== 1'b0 || rlog[0].rdata !== 16'h1234) begin
        failures++;
        $display("FAIL to_edge_ok: en=%0d err=%b rdata=%h required %0d 0 1234", xlog[0].en_cycles, rlog[0].err, rlog[0].rdata, TIMEOUT);
      end
      checks++;
      if (xlog[1].en_cycles != TIMEOUT || rlog[1].err !== 1'b1 || rlog[1].rdata !== 16'h0000) begin
        failures++;
        $display("FAIL to_abort: en=%0d err=%b rdata=%h required %0d 1 0000", xlog[1].en_cycles, rlog[1].err, rlog[1].rdata, TIMEOUT);
      end
    end
    checks++;
    if (busy !== 1'b0 || Psel !== 1'b0) begin
      failures++;
      $display("FAIL to_idle: busy=%b psel=%b required 0 0", busy, Psel);
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic        cw[N];
    logic [2:0]  ca[N];
    logic [15:0] cd[N];
    logic [15:0] rd[N];
    int          wn[N];
    bit          e;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      cw[i] = 1'($urandom);
      ca[i] = 3'($urandom);
      cd[i] = 16'($urandom);
      rd[i] = 16'($urandom);
      wn[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(0, TIMEOUT + 2);
      wait_q.push_back(wn[i]);
      rdata_q.push_back(rd[i]);
    end
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge Pclk);
      push(cw[i], ca[i], cd[i]);
    end
    wait_rsp(N, 5000);
    checks++;
    if (xlog.size() != N || rlog.size() != N || pulse_err != 0) begin
      failures++;
      $display("FAIL rnd_counts: xfers=%0d rsps=%0d pulse_err=%0d required %0d %0d 0", xlog.size(), rlog.size(), pulse_err, N, N);
    end
    for (int i = 0; i < N && i < xlog.size() && i < rlog.size(); i++) begin
      e = (wn[i] >= TIMEOUT);
      checks++;
      if (xlog[i].write !== cw[i] || xlog[i].addr !== ca[i] || xlog[i].wdata !== cd[i] || !xlog[i].stable ||
          xlog[i].en_cycles != (e ? TIMEOUT : wn[i] + 1)) begin
        failures++;
        $display("FAIL rnd_xfer[%0d]: w=%b a=%h d=%h stable=%0d en=%0d required w=%b a=%h d=%h stable=1 en=%0d",
                 i, xlog[i].write, xlog[i].addr, xlog[i].wdata, xlog[i].stable, xlog[i].en_cycles,
                 cw[i], ca[i], cd[i], e ? TIMEOUT : wn[i] + 1);
      end
      checks++;
      if (rlog[i].write !== cw[i] || rlog[i].err !== e || rlog[i].rdata !== ((cw[i] || e) ? 16'h0000 : rd[i]) ||
          rlog[i].cyc != xlog[i].end_cyc + 1) begin
        failures++;
        $display("FAIL rnd_rsp[%0d]: w=%b err=%b rdata=%h cyc=%0d required w=%b err=%b rdata=%h cyc=%0d",
                 i, rlog[i].write, rlog[i].err, rlog[i].rdata, rlog[i].cyc,
                 cw[i], e, (cw[i] || e) ? 16'h0000 : rd[i], xlog[i].end_cyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nx, nr;
    clear_logs();
    wait_q.push_back(100);
    for (int i = 0; i < 3; i++) push(1'b1, 3'(i + 4), 16'($urandom));
    @(negedge Pclk);
    checks++;
    if (Psel !== 1'b1 || Penable !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre: psel=%b pen=%b busy=%b required 1 1 1", Psel, Penable, busy);
    end
    #2 Prst = 1'b1;
    #1;
    checks++;
    if ({Psel, Penable, rsp_valid, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL rm_async: psel=%b pen=%b rv=%b busy=%b required 0 0 0 0", Psel, Penable, rsp_valid, busy);
    end
    @(negedge Pclk);
    Prst = 1'b0;
    wait_q.delete();
    nx = xlog.size();
    nr = rlog.size();
    repeat (30) @(negedge Pclk);
    checks++;
    if (xlog.size() != nx || rlog.size() != nr || cmd_ready !== 1'b1 || busy !== 1'b0 || Psel !== 1'b0) begin
      failures++;
      $display("FAIL rm_after: new_xfers=%0d new_rsps=%0d rdy=%b busy=%b psel=%b required 0 0 1 0 0",
               xlog.size() - nx, rlog.size() - nr, cmd_ready, busy, Psel);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_fifo_full();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
